sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
Parametrised N-way, WIDTH-bit selector with a registered, flow-controlled output stage; the next generation of the 5-bit 2:1 register-address mux. Selects one of NUM_IN input words per accepted transfer, tags it with the select value and an out-of-range error bit, and buffers up to two results in a skid buffer. Sits between decode and the register-file write port once the datapath is pipelined.

Parameters:
WIDTH, 5, bits per input word and per output word
NUM_IN, 2, number of input channels (>=2)
SEL_W, $clog2(NUM_IN) (min 1), select width; derived, not overridden
CNT_W, 8, error-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_sel  in  SEL_W  channel select
in_valid  in  1  upstream has a transfer
in_ready  out  1  block can accept this cycle
out_data  out  WIDTH  selected word (head entry)
out_sel  out  SEL_W  select value that produced out_data
out_err  out  1  in_sel was >= NUM_IN for this entry
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
clr_err  in  1  synchronous clear of err_count
err_count  out  CNT_W  saturating count of accepted out-of-range selects

Behaviour:
- Reset (rst_n low, asynchronous): buffer count=0, out_valid=0, out_data=0, out_sel=0, out_err=0, err_count=0; in_ready=0 while rst_n low.
- in_ready = rst_n && (count < 2); registered-state based, no combinational path from out_ready.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- Selection combinational on push: sel < NUM_IN -> word = channel sel, err=0; sel >= NUM_IN -> word = 0, err=1. Entry stores {word, sel, err}.
- Latency: push in cycle t -> out_valid=1 with that entry in cycle t+1 (buffer empty case).
- Buffer: 2-entry FIFO, head drives outputs. States EMPTY(0), ONE(1), FULL(2):
  EMPTY: push -> ONE.
  ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE (new entry becomes head next cycle).
  FULL: pop -> ONE (second entry promoted); no push possible.
- Sustained push+pop every cycle = throughput 1/cycle, order preserved.
- Output stable: while out_valid && !out_ready, out_data/out_sel/out_err unchanged.
- Popped entries with empty buffer: out_valid=0, out_data/out_sel/out_err hold last value (not cleared).
- err_count: +1 on each push with err=1; saturates at 2^CNT_W-1; clr_err same cycle as increment -> 0 (clear wins).
- Reset mid-transfer: buffered entries discarded, no partial output.
- NUM_IN power of 2: out-of-range impossible; err always 0.

Decomposition:
- Shared package: none required; WIDTH/NUM_IN defaults as constants in the datapath package if one exists.
- Sub-module skid_buf2 (2-entry FIFO, generic payload width WIDTH+SEL_W+1); top holds selection logic and error counter.

Test Plan:
- Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=0, err_count=0 immediately; after release in_ready=1.
- WIDTH=5, NUM_IN=2: in_data={5'h1F,5'h00}, sel=1, out_ready=1 -> next cycle out_data=5'h1F, out_sel=1, out_err=0; sel=0 -> 5'h00.
- Backpressure: out_ready=0, push three words A,B,C -> A,B accepted, in_ready=0 after second, C held; release out_ready -> A,B,C emerge in order, no loss or duplicates.
- Streaming: in_valid=out_ready=1 for 20 cycles, sel cycling -> 20 outputs, one per cycle, 1-cycle latency, in_ready never drops.
- NUM_IN=3, WIDTH=8: sel=3 -> out_data=0, out_err=1, err_count=1; 300 such pushes -> err_count=255; clr_err with concurrent error push -> err_count=0.
- Random valid/ready toggling vs. scoreboard model, 10k transfers -> exact match of data/sel/err sequence.

Source files
------------

// File: rtl/sel_mux_pipe_pkg.sv
// Shared constants and helpers for the selector pipeline.
//   WIDTH_DEF / NUM_IN_DEF / CNT_W_DEF : default datapath geometry
//   buf_state_e                        : occupancy of the 2-entry output buffer
//   sel_w()                            : select width for a given channel count
package sel_mux_pipe_pkg;

  localparam int unsigned WIDTH_DEF  = 5;
  localparam int unsigned NUM_IN_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // At least one select bit, even for a two-channel mux.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO with registered head; in_ready depends only on occupancy.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : upstream handshake, in_payload
//   out_valid/out_ready     : downstream handshake, out_payload = head entry
module skid_buf2
  import sel_mux_pipe_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  buf_state_e    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          valid_q, valid_d;
  logic          push_c, pop_c;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready = rst_n && (state_q != BUF_FULL);
  assign push_c   = in_valid && in_ready;
  assign pop_c    = valid_q && out_ready;

  // Occupancy transitions; head keeps its value when the buffer drains.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push_c) begin
          head_d  = in_payload;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push_c && !pop_c) begin
          tail_d  = in_payload;
          state_d = BUF_FULL;
        end else if (pop_c && !push_c) begin
          state_d = BUF_EMPTY;
        end else if (push_c && pop_c) begin
          head_d  = in_payload;
        end
      end
      BUF_FULL: begin
        if (pop_c) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    valid_d = (state_d != BUF_EMPTY);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = head_q;

endmodule

// File: rtl/sel_mux_pipe.sv
// N-way selector feeding a 2-entry output buffer, with out-of-range tagging
// and a saturating error counter.
//   in_data/in_sel/in_valid/in_ready : upstream transfer (channel k at [k*WIDTH +: WIDTH])
//   out_data/out_sel/out_err         : head entry, qualified by out_valid/out_ready
//   clr_err/err_count                : synchronous clear / count of bad selects
module sel_mux_pipe
  import sel_mux_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH  = WIDTH_DEF,
  parameter  int unsigned NUM_IN = NUM_IN_DEF,
  parameter  int unsigned CNT_W  = CNT_W_DEF,
  localparam int unsigned SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_err,
  output logic [CNT_W-1:0]        err_count
);

  localparam int unsigned PW = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] word_c;
  logic             err_c;
  logic             push_c;
  logic [PW-1:0]    in_payload_c;
  logic [PW-1:0]    out_payload_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Channel select; an out-of-range select yields a zero word.
  always_comb begin
    word_c = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) word_c = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign err_c        = (32'(in_sel) >= NUM_IN);
  assign in_payload_c = {word_c, in_sel, err_c};
  assign push_c       = in_valid && in_ready;

  skid_buf2 #(
    .PW(PW)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload_c)
  );

  assign out_data = out_payload_c[PW-1 -: WIDTH];
  assign out_sel  = out_payload_c[1 +: SEL_W];
  assign out_err  = out_payload_c[0];

  // Saturating error counter; clear takes priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      cnt_d = '0;
    end else if (push_c && err_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Scoreboard bench: two instances (5-bit x2 channels, 8-bit x3 channels),
// expected entries queued on accepted transfers, checked as they are popped.
module tb_sel_mux_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: WIDTH=5, NUM_IN=2
  logic [9:0] a_in_data;
  logic [0:0] a_in_sel;
  logic       a_in_valid, a_in_ready;
  logic [4:0] a_out_data;
  logic [0:0] a_out_sel;
  logic       a_out_err, a_out_valid, a_out_ready, a_clr;
  logic [7:0] a_err_count;

  // Instance B: WIDTH=8, NUM_IN=3
  logic [23:0] b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_err, b_out_valid, b_out_ready, b_clr;
  logic [7:0]  b_err_count;

  sel_mux_pipe #(.WIDTH(5), .NUM_IN(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .clr_err(a_clr), .err_count(a_err_count)
  );

  sel_mux_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .clr_err(b_clr), .err_count(b_err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int a_pops   = 0;
  int b_pops   = 0;

  logic [6:0]  qa[$];
  logic [10:0] qb[$];
  int          cnt_m = 0;
  logic [10:0] last_b;
  logic        have_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor A: occupancy follows the model queue; popped entries match it.
  always @(negedge clk) begin : mon_a
    logic [6:0] e;
    logic [4:0] w;
    if (!rst_n) begin
      qa.delete();
    end else begin
      chk("a_valid", 32'(a_out_valid), 32'(qa.size() != 0));
      chk("a_ready", 32'(a_in_ready), 32'(qa.size() < 2));
      chk("a_errcnt", 32'(a_err_count), 0);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_pop", qa.size(), 1);
        else begin
          e = qa.pop_front();
          chk("a_entry", 32'({a_out_data, a_out_sel, a_out_err}), 32'(e));
          a_pops++;
        end
      end
      if (a_in_valid && a_in_ready) begin
        w = a_in_data[int'(a_in_sel)*5 +: 5];
        qa.push_back({w, a_in_sel, 1'b0});
      end
    end
  end

  // Monitor B: also models the saturating error count and the hold-after-drain rule.
  always @(negedge clk) begin : mon_b
    logic [10:0] e;
    logic [7:0]  w;
    logic        er;
    logic        acc;
    if (!rst_n) begin
      qb.delete();
      cnt_m     = 0;
      have_last = 1'b0;
    end else begin
      chk("b_valid", 32'(b_out_valid), 32'(qb.size() != 0));
      chk("b_ready", 32'(b_in_ready), 32'(qb.size() < 2));
      chk("b_errcnt", 32'(b_err_count), cnt_m);
      if (!b_out_valid && have_last)
        chk("b_hold", 32'({b_out_data, b_out_sel, b_out_err}), 32'(last_b));
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_pop", qb.size(), 1);
        else begin
          e = qb.pop_front();
          chk("b_entry", 32'({b_out_data, b_out_sel, b_out_err}), 32'(e));
          last_b    = e;
          have_last = 1'b1;
          b_pops++;
        end
      end
      acc = b_in_valid && b_in_ready;
      er  = (b_in_sel >= 2'd3);
      w   = er ? 8'h00 : b_in_data[int'(b_in_sel)*8 +: 8];
      if (acc) qb.push_back({w, b_in_sel, er});
      if (b_clr) cnt_m = 0;
      else if (acc && er && cnt_m != 255) cnt_m++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a B transfer until accepted, bounded.
  task automatic send_b(input logic [23:0] d, input logic [1:0] s);
    logic ok;
    logic done;
    done       = 1'b0;
    b_in_data  = d;
    b_in_sel   = s;
    b_in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      ok = b_in_ready;
      step();
      if (ok) done = 1'b1;
    end
    b_in_valid = 1'b0;
    if (!done) chk("send_b_timeout", 32'(done), 1);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0;
    a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_clr = 1'b0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_clr = 1'b0;
    step(); step();

    // Reset values
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_ready", 32'(a_in_ready), 0);
    chk("rst_b_valid", 32'(b_out_valid), 0);
    chk("rst_b_ready", 32'(b_in_ready), 0);
    chk("rst_b_out", 32'({b_out_data, b_out_sel, b_out_err}), 0);
    chk("rst_b_errcnt", 32'(b_err_count), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_a_ready", 32'(a_in_ready), 1);
    chk("rel_b_ready", 32'(b_in_ready), 1);
    step();

    // 2:1 basic selection, one-cycle latency
    a_out_ready = 1'b1;
    a_in_data   = {5'h1F, 5'h00};
    a_in_sel    = 1'b1;
    a_in_valid  = 1'b1;
    step();
    chk("a_sel1_data", 32'(a_out_data), 32'h1F);
    chk("a_sel1_sel", 32'(a_out_sel), 1);
    chk("a_sel1_valid", 32'(a_out_valid), 1);
    a_in_sel = 1'b0;
    step();
    chk("a_sel0_data", 32'(a_out_data), 0);
    chk("a_sel0_err", 32'(a_out_err), 0);
    a_in_valid = 1'b0;
    step();

    // Backpressure: A,B accepted, C held until the head drains
    b_out_ready = 1'b0;
    send_b(24'h0000AA, 2'd0);
    send_b(24'h00BB00, 2'd1);
    chk("bp_ready_low", 32'(b_in_ready), 0);
    b_in_data = 24'hCC0000; b_in_sel = 2'd2; b_in_valid = 1'b1;
    step(); step(); step();
    chk("bp_still_full", 32'(b_in_ready), 0);
    chk("bp_head_stable", 32'(b_out_data), 32'hAA);
    p0 = b_pops;
    b_out_ready = 1'b1;
    send_b(24'hCC0000, 2'd2);
    step(); step(); step();
    chk("bp_pop_count", b_pops - p0, 3);

    // Streaming: one transfer per cycle, in_ready never drops
    p0 = b_pops;
    for (int i = 0; i < 20; i++) begin
      b_in_valid = 1'b1;
      b_in_sel   = 2'(i % 4);
      b_in_data  = 24'($urandom);
      chk("stream_ready", 32'(b_in_ready), 1);
      step();
    end
    b_in_valid = 1'b0;
    step();
    chk("stream_count", b_pops - p0, 20);

    // Out-of-range select
    b_clr = 1'b1; step(); b_clr = 1'b0;
    send_b(24'h123456, 2'd3);
    chk("oor_data", 32'(b_out_data), 0);
    chk("oor_err", 32'(b_out_err), 1);
    chk("oor_cnt", 32'(b_err_count), 1);
    b_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b_in_data = 24'($urandom);
      step();
    end
    b_in_valid = 1'b0;
    step();
    chk("err_sat", 32'(b_err_count), 255);
    b_clr = 1'b1; b_in_valid = 1'b1; b_in_sel = 2'd3;
    step();
    b_clr = 1'b0; b_in_valid = 1'b0;
    chk("err_clr_wins", 32'(b_err_count), 0);
    step(); step();

    // Random valid/ready traffic
    p0 = b_pops;
    for (int c = 0; c < 60000 && (b_pops - p0) < 10000; c++) begin
      b_in_valid  = ($urandom_range(3, 0) != 0);
      b_out_ready = ($urandom_range(3, 0) != 0);
      b_in_sel    = 2'($urandom_range(3, 0));
      b_in_data   = 24'($urandom);
      b_clr       = ($urandom_range(63, 0) == 0);
      a_in_valid  = ($urandom_range(1, 0) != 0);
      a_out_ready = ($urandom_range(1, 0) != 0);
      a_in_sel    = 1'($urandom_range(1, 0));
      a_in_data   = 10'($urandom);
      step();
    end
    chk("rand_transfers", 32'((b_pops - p0) >= 10000), 1);
    b_in_valid = 1'b0; a_in_valid = 1'b0; b_clr = 1'b0;
    b_out_ready = 1'b1; a_out_ready = 1'b1;
    step(); step(); step();

    // Reset mid-transfer with a full buffer
    b_out_ready = 1'b0;
    send_b(24'h000011, 2'd3);
    send_b(24'h002200, 2'd1);
    b_in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(b_out_valid), 0);
    chk("mrst_ready", 32'(b_in_ready), 0);
    chk("mrst_errcnt", 32'(b_err_count), 0);
    chk("mrst_data", 32'(b_out_data), 0);
    b_in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_ready", 32'(b_in_ready), 1);
    step(); step();
    chk("mrst_no_output", 32'(b_out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
